// File: rtl/chunked_ripple_adder.sv
// chunked_ripple_adder: multi-cycle add/subtract, CHUNK bits per enabled cycle, LSB chunk first.
module chunked_ripple_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             start,
    input  logic             sub,
    input  logic             Cin,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             Ovf,
    output logic             busy,
    output logic             done
);
    localparam int NCH = WIDTH / CHUNK;
    localparam int KW  = NCH > 1 ? $clog2(NCH) : 1;

    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
        $error("WIDTH must be a multiple of CHUNK");
    end

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d;
    logic [KW-1:0]    k_q, k_d;
    logic             c_q, c_d, cout_q, cout_d, ovf_q, ovf_d, done_q, done_d;
    logic [CHUNK-1:0] a_ch, b_ch;
    logic [CHUNK:0]   sum;
    logic             last;

    assign a_ch = a_q[k_q*CHUNK +: CHUNK];
    assign b_ch = b_q[k_q*CHUNK +: CHUNK];
    assign sum  = {1'b0, a_ch} + {1'b0, b_ch} + {{CHUNK{1'b0}}, c_q};
    assign last = k_q == KW'(NCH - 1);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        k_d     = k_q;
        c_d     = c_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        if (state_q == IDLE && start) begin
            a_d     = A;
            b_d     = sub ? ~B : B;
            c_d     = sub | Cin;
            k_d     = '0;
            state_d = RUN;
        end else if (state_q == RUN) begin
            s_d[k_q*CHUNK +: CHUNK] = sum[CHUNK-1:0];
            c_d = sum[CHUNK];
            k_d = k_q + 1'b1;
            if (last) begin
                cout_d  = sum[CHUNK];
                // carry into the MSB recovered from the MSB sum bit
                ovf_d   = sum[CHUNK] ^ (a_ch[CHUNK-1] ^ b_ch[CHUNK-1] ^ sum[CHUNK-1]);
                done_d  = 1'b1;
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            k_q     <= '0;
            c_q     <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else if (en) begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            k_q     <= k_d;
            c_q     <= c_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign S    = s_q;
    assign Cout = cout_q;
    assign Ovf  = ovf_q;
    assign busy = state_q == RUN;
    assign done = done_q;
endmodule

// File: tb/tb_chunked_ripple_adder.sv
// tb_chunked_ripple_adder: directed and randomized checks of three adder configurations.
module tb_chunked_ripple_adder;
    logic        clk = 1'b0;
    logic        rst = 1'b1, en = 1'b1, sub = 1'b0, cin = 1'b0;
    logic [2:0]  start = '0;
    logic [31:0] a = '0, b = '0;
    logic [15:0] s16;
    logic [31:0] s32;
    logic [7:0]  s8;
    logic [2:0]  co, ov, bz, dn;
    int          sel = 0;
    logic [31:0] obs_s;
    logic        obs_c, obs_v, obs_d;
    int          passed = 0, total = 0;

    always #5 clk = ~clk;

    chunked_ripple_adder #(.WIDTH(16), .CHUNK(4)) u16 (
        .clk(clk), .rst(rst), .en(en), .start(start[0]), .sub(sub), .Cin(cin),
        .A(a[15:0]), .B(b[15:0]), .S(s16), .Cout(co[0]), .Ovf(ov[0]), .busy(bz[0]), .done(dn[0]));
    chunked_ripple_adder #(.WIDTH(32), .CHUNK(8)) u32 (
        .clk(clk), .rst(rst), .en(en), .start(start[1]), .sub(sub), .Cin(cin),
        .A(a), .B(b), .S(s32), .Cout(co[1]), .Ovf(ov[1]), .busy(bz[1]), .done(dn[1]));
    chunked_ripple_adder #(.WIDTH(8), .CHUNK(8)) u8 (
        .clk(clk), .rst(rst), .en(en), .start(start[2]), .sub(sub), .Cin(cin),
        .A(a[7:0]), .B(b[7:0]), .S(s8), .Cout(co[2]), .Ovf(ov[2]), .busy(bz[2]), .done(dn[2]));

    always_comb begin
        obs_s = sel == 0 ? {16'h0, s16} : sel == 1 ? s32 : {24'h0, s8};
        obs_c = co[sel];
        obs_v = ov[sel];
        obs_d = dn[sel];
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Reference: plain modular arithmetic with signed-overflow rule; returns {ovf, cout, sum}.
    function automatic logic [33:0] model(input int w, input logic [31:0] xa, xb, input logic xs, xc);
        logic [63:0] mask, am, bm, r;
        logic        sa, sb, sr, c;
        mask = (64'd1 << w) - 64'd1;
        am = {32'h0, xa} & mask;
        bm = {32'h0, xb} & mask;
        r  = xs ? ((am - bm) & mask) : am + bm + {63'h0, xc};
        c  = xs ? (am >= bm) : r[w];
        r  = r & mask;
        sa = am[w-1];
        sb = bm[w-1];
        sr = r[w-1];
        return {xs ? (sa != sb && sr != sa) : (sa == sb && sr != sa), c, r[31:0]};
    endfunction

    task automatic test_reset;
        rst = 1'b1; en = 1'b1; start = '0;
        step;
        total++; if (s16 !== 16'h0) $display("FAIL reset_s: got %h want 0000", s16); else passed++;
        total++; if ({co[0], ov[0], bz[0], dn[0]} !== 4'b0) $display("FAIL reset_flags: got %b want 0000", {co[0], ov[0], bz[0], dn[0]}); else passed++;
        rst = 1'b0;
        step;
    endtask

    task automatic do_op16(input logic [15:0] xa, xb, input logic xs, xc, input logic [15:0] es, input logic ec, ev);
        int n;
        sel = 0; a = {16'h0, xa}; b = {16'h0, xb}; sub = xs; cin = xc; start[0] = 1'b1;
        step;
        start[0] = 1'b0; a = 32'hdead_beef; b = 32'h1357_9bdf; sub = ~xs; cin = ~xc;
        total++; if (bz[0] !== 1'b1) $display("FAIL op_busy: got %b want 1", bz[0]); else passed++;
        n = 0;
        do begin step; n++; end while (!dn[0] && n < 20);
        total++; if (n !== 4) $display("FAIL op_latency %h/%h: got %0d want 4", xa, xb, n); else passed++;
        total++; if (s16 !== es) $display("FAIL op_s %h/%h sub=%b: got %h want %h", xa, xb, xs, s16, es); else passed++;
        total++; if (co[0] !== ec) $display("FAIL op_cout %h/%h: got %b want %b", xa, xb, co[0], ec); else passed++;
        total++; if (ov[0] !== ev) $display("FAIL op_ovf %h/%h: got %b want %b", xa, xb, ov[0], ev); else passed++;
        step;
        total++; if (dn[0] !== 1'b0) $display("FAIL op_done_clear: got %b want 0", dn[0]); else passed++;
        total++; if (s16 !== es) $display("FAIL op_s_hold: got %h want %h", s16, es); else passed++;
    endtask

    task automatic test_arith;
        do_op16(16'h0005, 16'h0005, 1'b0, 1'b0, 16'h000A, 1'b0, 1'b0);
        do_op16(16'h0006, 16'h0006, 1'b0, 1'b0, 16'h000C, 1'b0, 1'b0);
        do_op16(16'h0007, 16'h0007, 1'b0, 1'b0, 16'h000E, 1'b0, 1'b0);
        do_op16(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        do_op16(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        do_op16(16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0);
        do_op16(16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        do_op16(16'h1234, 16'h0001, 1'b0, 1'b1, 16'h1236, 1'b0, 1'b0);
    endtask

    task automatic test_stall;
        int n;
        sel = 0; a = 32'h1234; b = 32'h1111; sub = 1'b0; cin = 1'b0; start[0] = 1'b1;
        step;
        a = 32'hFFFF; b = 32'hFFFF; sub = 1'b1;
        n = 0;
        do begin
            n++;
            en = (n >= 3 && n <= 5) ? 1'b0 : 1'b1;
            step;
            if (n >= 3 && n <= 5) begin
                total++; if ({bz[0], dn[0]} !== 2'b10) $display("FAIL stall_hold: got busy,done=%b want 10", {bz[0], dn[0]}); else passed++;
            end
        end while (!dn[0] && n < 20);
        start[0] = 1'b0; en = 1'b1;
        total++; if (n !== 7) $display("FAIL stall_latency: got %0d want 7", n); else passed++;
        total++; if (s16 !== 16'h2345) $display("FAIL stall_s: got %h want 2345", s16); else passed++;
        en = 1'b0;
        step;
        total++; if ({dn[0], bz[0]} !== 2'b10) $display("FAIL stall_done_frozen: got done,busy=%b want 10", {dn[0], bz[0]}); else passed++;
        en = 1'b1;
        step;
        total++; if (dn[0] !== 1'b0) $display("FAIL stall_done_clear: got %b want 0", dn[0]); else passed++;
        total++; if (s16 !== 16'h2345) $display("FAIL stall_s_hold: got %h want 2345", s16); else passed++;
    endtask

    task automatic test_reset_mid;
        int seen;
        sel = 0; a = 32'h1234; b = 32'h1111; sub = 1'b0; cin = 1'b0; start[0] = 1'b1;
        step;
        start[0] = 1'b0;
        step;
        step;
        rst = 1'b1;
        step;
        rst = 1'b0;
        total++; if ({s16, co[0], ov[0], bz[0], dn[0]} !== 20'h0) $display("FAIL rstmid_zero: got s=%h flags=%b want 0", s16, {co[0], ov[0], bz[0], dn[0]}); else passed++;
        seen = 0;
        for (int i = 0; i < 5; i++) begin step; seen += int'(dn[0]) + int'(bz[0]); end
        total++; if (seen !== 0) $display("FAIL rstmid_no_done: got %0d activity cycles want 0", seen); else passed++;
        do_op16(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back(input int s, input int w, input int nch, input int nops);
        logic [33:0] exp;
        int n;
        sel = s;
        a = $urandom; b = $urandom; sub = 1'($urandom); cin = 1'($urandom);
        exp = model(w, a, b, sub, cin);
        start[s] = 1'b1;
        step;
        for (int i = 0; i < nops; i++) begin
            start[s] = 1'b0;
            a = $urandom; b = $urandom; sub = 1'($urandom); cin = 1'($urandom);
            n = 0;
            do begin step; n++; end while (!obs_d && n < 40);
            total++; if (n !== nch) $display("FAIL rand%0d_latency op%0d: got %0d want %0d", w, i, n, nch); else passed++;
            total++; if (obs_s !== exp[31:0]) $display("FAIL rand%0d_s op%0d: got %h want %h", w, i, obs_s, exp[31:0]); else passed++;
            total++; if ({obs_v, obs_c} !== exp[33:32]) $display("FAIL rand%0d_flags op%0d: got ovf,cout=%b want %b", w, i, {obs_v, obs_c}, exp[33:32]); else passed++;
            if (i < nops - 1) begin
                a = $urandom; b = $urandom; sub = 1'($urandom); cin = 1'($urandom);
                if (i % 5 == 0) b = a;
                exp = model(w, a, b, sub, cin);
                start[s] = 1'b1;
                step;
            end
        end
        start[s] = 1'b0;
        step;
    endtask

    initial begin
        test_reset;
        test_arith;
        test_stall;
        test_reset_mid;
        test_back_to_back(0, 16, 4, 40);
        test_back_to_back(1, 32, 4, 40);
        test_back_to_back(2, 8, 1, 40);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
